// File: rtl/collision_scan_ctrl_pkg.sv
// Shared types and helpers for the two-snake collision scanner.
// Provides the default sizes, the scan state encoding, segment extraction
// from a packed body bus, and length clamping.
package collision_scan_ctrl_pkg;

    localparam int MAX_LEN = 16;
    localparam int NUM_LEN = 10;
    localparam int LEN_W   = 4;
    localparam int IDX_W   = LEN_W + 1;
    localparam int BUS_W   = MAX_LEN * NUM_LEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN1 = 2'd1,
        ST_SCAN2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Segment idx of a packed body; out-of-range indices read as 0.
    function automatic logic [NUM_LEN-1:0] seg_at(input logic [BUS_W-1:0] body,
                                                  input logic [IDX_W-1:0] idx);
        logic [NUM_LEN-1:0] seg;
        seg = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == IDX_W'(i)) seg = body[i*NUM_LEN +: NUM_LEN];
        end
        return seg;
    endfunction

    // Effective segment count: min(len, MAX_LEN).
    function automatic logic [IDX_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return ({1'b0, len} > IDX_W'(MAX_LEN)) ? IDX_W'(MAX_LEN) : {1'b0, len};
    endfunction

endpackage

// File: rtl/collision_scan_ctrl_if.sv
// Request/result bundle between the game tick FSM (master) and the
// collision scanner (slave).
//   start          request a scan
//   snake1/snake2  packed bodies, segment 0 is the head
//   len1/len2      body lengths in segments
//   busy/done      scan in progress / one-cycle completion pulse
//   dead1/dead2    held collision results
interface collision_scan_ctrl_if;
    import collision_scan_ctrl_pkg::*;

    logic             start;
    logic [BUS_W-1:0] snake1;
    logic [BUS_W-1:0] snake2;
    logic [LEN_W-1:0] len1;
    logic [LEN_W-1:0] len2;
    logic             busy;
    logic             done;
    logic             dead1;
    logic             dead2;

    modport master (
        output start, snake1, snake2, len1, len2,
        input  busy, done, dead1, dead2
    );

    modport slave (
        input  start, snake1, snake2, len1, len2,
        output busy, done, dead1, dead2
    );

endinterface

// File: rtl/collision_scan_ctrl_seg_mux.sv
// Shared segment selector: picks segment idx from either snapshot body.
//   s1, s2  snapshot bodies
//   sel     0 selects s1, 1 selects s2
//   idx     segment index
//   seg     selected segment
module collision_scan_ctrl_seg_mux
    import collision_scan_ctrl_pkg::*;
(
    input  logic [BUS_W-1:0]   s1,
    input  logic [BUS_W-1:0]   s2,
    input  logic               sel,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_LEN-1:0] seg
);

    assign seg = seg_at(sel ? s2 : s1, idx);

endmodule

// File: rtl/collision_scan_ctrl.sv
// Sequential collision scheduler: one comparator walks both snapshot bodies,
// one segment per clock, checking each segment against both heads.
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of collision_scan_ctrl_if (start/bodies/lengths in,
//          busy/done/dead1/dead2 out, all outputs registered)
//
// state  | meaning
// IDLE   | waiting for start; snapshot taken on accept
// SCAN1  | comparing s1[idx], idx = 1..n1-1
// SCAN2  | comparing s2[idx], idx = 1..n2-1
// DONE   | done pulse; dead1/dead2 loaded on entry
module collision_scan_ctrl
    import collision_scan_ctrl_pkg::*;
#(
    parameter bit HEAD_ON = 1'b1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    collision_scan_ctrl_if.slave  bus
);

    state_t             state;
    logic [BUS_W-1:0]   s1_q, s2_q;
    logic [IDX_W-1:0]   n1_q, n2_q, idx_q;
    logic               hit1_q, hit2_q;
    logic               busy_q, done_q, dead1_q, dead2_q;

    logic [NUM_LEN-1:0] seg, h1, h2;
    logic               sel_s2;
    logic               hit1_nx, hit2_nx;
    logic               last1, last2;
    logic [IDX_W-1:0]   n1_in, n2_in;
    logic               head_on_in;

    assign sel_s2 = (state == ST_SCAN2);

    collision_scan_ctrl_seg_mux u_seg_mux (
        .s1  (s1_q),
        .s2  (s2_q),
        .sel (sel_s2),
        .idx (idx_q),
        .seg (seg)
    );

    assign h1      = seg_at(s1_q, '0);
    assign h2      = seg_at(s2_q, '0);
    // The segment under the comparator is checked against both heads,
    // so a single pass over each body resolves self- and cross-bites.
    assign hit1_nx = hit1_q | (seg == h1);
    assign hit2_nx = hit2_q | (seg == h2);
    assign last1   = (idx_q == n1_q - IDX_W'(1));
    assign last2   = (idx_q == n2_q - IDX_W'(1));

    assign n1_in      = eff_len(bus.len1);
    assign n2_in      = eff_len(bus.len2);
    assign head_on_in = HEAD_ON && (n1_in != '0) && (n2_in != '0) &&
                        (seg_at(bus.snake1, '0) == seg_at(bus.snake2, '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            idx_q   <= '0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dead1_q <= 1'b0;
            dead2_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        s1_q   <= bus.snake1;
                        s2_q   <= bus.snake2;
                        n1_q   <= n1_in;
                        n2_q   <= n2_in;
                        idx_q  <= IDX_W'(1);
                        hit1_q <= head_on_in;
                        hit2_q <= head_on_in;
                        busy_q <= 1'b1;
                        // Bodies shorter than two segments are skipped outright.
                        if (n1_in >= IDX_W'(2)) begin
                            state <= ST_SCAN1;
                        end else if (n2_in >= IDX_W'(2)) begin
                            state <= ST_SCAN2;
                        end else begin
                            state   <= ST_DONE;
                            done_q  <= 1'b1;
                            dead1_q <= head_on_in;
                            dead2_q <= head_on_in;
                        end
                    end
                end
                ST_SCAN1: begin
                    hit1_q <= hit1_nx;
                    hit2_q <= hit2_nx;
                    if (last1) begin
                        idx_q <= IDX_W'(1);
                        if (n2_q >= IDX_W'(2)) begin
                            state <= ST_SCAN2;
                        end else begin
                            state   <= ST_DONE;
                            done_q  <= 1'b1;
                            dead1_q <= hit1_nx;
                            dead2_q <= hit2_nx;
                        end
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_SCAN2: begin
                    hit1_q <= hit1_nx;
                    hit2_q <= hit2_nx;
                    if (last2) begin
                        state   <= ST_DONE;
                        done_q  <= 1'b1;
                        dead1_q <= hit1_nx;
                        dead2_q <= hit2_nx;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // start here is dropped: DONE always returns to IDLE.
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.dead1 = dead1_q;
    assign bus.dead2 = dead2_q;

endmodule
